lbist_engine: RTL

LBIST_ENGINE -- requirements
Module: lbist_engine

---
 rtl/lbist_pkg.sv | 19 +
 rtl/lbist_lfsr.sv | 38 +++
 rtl/lbist_engine.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lbist_pkg.sv
// Shared types and the Galois LFSR step used by the logic BIST engine.
package lbist_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun,
      StDone
   } state_e;

   localparam int unsigned MaxWidth = 32;

   // Operands are zero-extended to MaxWidth; callers truncate the result back.
   function automatic logic [MaxWidth-1:0] galois_step(input logic [MaxWidth-1:0] x,
                                                       input logic [MaxWidth-1:0] poly);
      return (x >> 1) ^ (x[0] ? poly : '0);
   endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// Galois LFSR with parallel load and XOR injection; serves as PRPG (inject=0) or MISR.
module lbist_lfsr
   import lbist_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hB8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] inject,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d = WIDTH'(galois_step(MaxWidth'(q_q), MaxWidth'(POLY))) ^ inject;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/lbist_engine.sv
// Logic BIST controller: seeds a PRPG, compacts CUT responses in a MISR, compares to golden.
module lbist_engine
   import lbist_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] POLY       = WIDTH'(8'hB8),
   parameter int unsigned      N_PATTERNS = 255
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] golden,
   input  logic [WIDTH-1:0] cut_resp,
   output logic [WIDTH-1:0] prpg_out,
   output logic [WIDTH-1:0] signature,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   localparam int unsigned     CntW    = $clog2(N_PATTERNS + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(N_PATTERNS - 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic             lfsr_load, lfsr_en;
   logic [WIDTH-1:0] misr_next;

   // MISR value the final RUN edge will produce, so pass is valid on DONE entry.
   assign misr_next = WIDTH'(galois_step(MaxWidth'(signature), MaxWidth'(POLY))) ^ cut_resp;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      seed_d    = seed_q;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StLoad;
               pass_d  = 1'b0;
               seed_d  = (seed == '0) ? WIDTH'(1) : seed;
            end
         end
         StLoad: begin
            if (abort) begin
               state_d = StIdle;
               pass_d  = 1'b0;
            end else begin
               lfsr_load = 1'b1;
               cnt_d     = '0;
               state_d   = StRun;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
               pass_d  = 1'b0;
            end else begin
               lfsr_en = 1'b1;
               cnt_d   = cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
                  pass_d  = (misr_next == golden);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CK) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         seed_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         seed_q  <= seed_d;
      end
   end

   lbist_lfsr #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_prpg (
      .clk      (CK),
      .reset    (reset),
      .load     (lfsr_load),
      .load_val (seed_q),
      .en       (lfsr_en),
      .inject   ({WIDTH{1'b0}}),
      .q        (prpg_out)
   );

   lbist_lfsr #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_misr (
      .clk      (CK),
      .reset    (reset),
      .load     (lfsr_load),
      .load_val ({WIDTH{1'b0}}),
      .en       (lfsr_en),
      .inject   (cut_resp),
      .q        (signature)
   );

   assign busy = (state_q == StLoad) || (state_q == StRun);
   assign done = (state_q == StDone);
   assign pass = pass_q;

endmodule
